// File: rtl/spinner_pipe.sv
// spinner_pipe: two-stage pipelined barrel rotator / logical shifter.
// Requests come in over a valid/ready handshake. Stage 1 registers the request.
// A combinational log-shifter sits between stage 1 and stage 2.
// Stage 2 holds the result for the consumer.
// Optional feature macro: SPINNER_SPIN_EN. When it is defined, a request can use
// the last produced result as its operand ("spin") instead of in_data.
module spinner_pipe #(
  parameter  int WIDTH = 32,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_spin,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_ROL = 2'b01,
    OP_SHR = 2'b10,
    OP_SHL = 2'b11
  } op_e;

  // Stage 1 request registers
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [AMT_W-1:0] s1_amount_q, s1_amount_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;

  // Stage 2 result registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             s1_advance;
  logic             accept;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] shift_out;

  assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign accept     = in_valid && in_ready;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

`ifdef SPINNER_SPIN_EN
  logic s1_spin_q, s1_spin_d;

  // Capture the spin bit alongside the rest of the request.
  always_comb begin
    s1_spin_d = s1_spin_q;
    if (accept) begin
      s1_spin_d = in_spin;
    end
  end

  // Register the spin bit; cleared on reset so no stale spin survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_spin_q <= 1'b0;
    end else begin
      s1_spin_q <= s1_spin_d;
    end
  end

  // The S2 result register always holds the predecessor's result when S1 advances.
  // Spin entries can therefore take their operand straight from it.
  assign shift_in = s1_spin_q ? out_data_q : s1_data_q;
`else
  logic unused_spin;
  assign unused_spin = in_spin;
  assign shift_in    = s1_data_q;
`endif

  // Log-shifter: layer k moves the operand by 2^k when amount bit k is set.
  always_comb begin
    shift_out = shift_in;
    for (int k = 0; k < AMT_W; k++) begin
      if (s1_amount_q[k]) begin
        case (s1_op_q)
          OP_ROR:  shift_out = (shift_out >> (2 ** k)) | (shift_out << (WIDTH - 2 ** k));
          OP_ROL:  shift_out = (shift_out << (2 ** k)) | (shift_out >> (WIDTH - 2 ** k));
          OP_SHR:  shift_out = shift_out >> (2 ** k);
          default: shift_out = shift_out << (2 ** k);
        endcase
      end
    end
  end

  // Stage 1 next state.
  // S1 loads on acceptance and empties when it advances without a refill.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_amount_d = s1_amount_q;
    s1_data_d   = s1_data_q;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_op_d     = op_e'(in_op);
      s1_amount_d = in_amount;
      s1_data_d   = in_data;
    end else if (s1_advance) begin
      s1_valid_d  = 1'b0;
    end
  end

  // Stage 2 next state.
  // The result register only changes when S2 loads, so it is stable under stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s1_advance) begin
      out_valid_d = 1'b1;
      out_data_d  = shift_out;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards every in-flight entry and zeroes the result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ROR;
      s1_amount_q <= '0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_amount_q <= s1_amount_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_spinner_pipe.sv
// tb_spinner_pipe: self-checking bench for spinner_pipe at WIDTH = 32.
// Inputs are driven on the falling edge. Handshakes and outputs are sampled
// just before the next rising edge.
// A reference model computes every expected result bit by bit from the
// operation rules. Results are queued in request order.
module tb_spinner_pipe;

  localparam int W = 32;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [4:0]    in_amount;
  logic          in_spin;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  int            compareCount;
  int            mismatchCount;

  logic [W-1:0]  expQ[$];
  logic [W-1:0]  gotQ[$];
  logic [W-1:0]  lastResult;
  logic          lastAccepted;
  logic          outValidSeen;
  logic          inReadySeen;
  logic [W-1:0]  outDataSeen;

  spinner_pipe #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amount (in_amount),
    .in_spin   (in_spin),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: each result bit is picked from the source bit it came from.
  function automatic logic [W-1:0] modelOp(input logic [1:0] op, input int amt,
                                           input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (op)
        2'b00:   r[i] = d[(i + amt) % W];
        2'b01:   r[i] = d[(i - amt + W) % W];
        2'b10:   r[i] = (i + amt < W) ? d[i + amt] : 1'b0;
        default: r[i] = (i >= amt) ? d[i - amt] : 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive the inputs, let them settle, then score this edge's handshakes.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [4:0] amt,
                               input logic spin, input logic [W-1:0] data, input logic rdy);
    logic [W-1:0] operand;
    logic [W-1:0] res;
    @(negedge clock);
    in_valid  = v;
    in_op     = op;
    in_amount = amt;
    in_spin   = spin;
    in_data   = data;
    out_ready = rdy;
    #1;
    outValidSeen = out_valid;
    outDataSeen  = out_data;
    inReadySeen  = in_ready;
    if (out_valid && out_ready) begin
      gotQ.push_back(out_data);
      if (expQ.size() == 0) begin
        checkOutput("spuriousResult", 32'(expQ.size()), 32'd1);
      end else begin
        checkOutput("result", out_data, expQ.pop_front());
      end
    end
    lastAccepted = in_valid && in_ready;
    if (lastAccepted) begin
`ifdef SPINNER_SPIN_EN
      operand = spin ? lastResult : data;
`else
      operand = data;
`endif
      res        = modelOp(op, int'(amt), operand);
      lastResult = res;
      expQ.push_back(res);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 5'd0, 1'b0, '0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
    checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] firstRes;
    logic [W-1:0] reqData[3];
    int           accepts;
    int           head;

    compareCount  = 0;
    mismatchCount = 0;
    lastResult    = '0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_amount = '0;
    in_spin   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state.
    #1;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutData", out_data, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    checkOutput("rstInReady", 32'(inReadySeen), 32'd1);

    // Latency and first rotate-right result.
    gotQ.delete();
    applyStimulus(1'b1, 2'b00, 5'd4, 1'b0, 32'h12345678, 1'b1);
    checkOutput("firstAccept", 32'(lastAccepted), 32'd1);
    idle(1);
    checkOutput("latencyNotYet", 32'(outValidSeen), 32'd0);
    idle(1);
    checkOutput("latencyValid", 32'(outValidSeen), 32'd1);
    checkOutput("rorValue", outDataSeen, 32'h81234567);

    // The other three operations, issued back to back.
    gotQ.delete();
    applyStimulus(1'b1, 2'b01, 5'd8, 1'b0, 32'h80000001, 1'b1);
    applyStimulus(1'b1, 2'b10, 5'd31, 1'b0, 32'h80000000, 1'b1);
    applyStimulus(1'b1, 2'b11, 5'd1, 1'b0, 32'h80000001, 1'b1);
    drain();
    checkOutput("opCount", 32'(gotQ.size()), 32'd3);
    if (gotQ.size() == 3) begin
      checkOutput("rolValue", gotQ[0], 32'h00000180);
      checkOutput("shrValue", gotQ[1], 32'h00000001);
      checkOutput("shlValue", gotQ[2], 32'h00000002);
    end

`ifdef SPINNER_SPIN_EN
    // Back-to-back spins: each operand is the previous result.
    gotQ.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 4, 2'b01, 5'd1, i > 0, (i == 0) ? 32'h1 : 32'hFFFFFFFF, 1'b1);
      if (i >= 2) checkOutput("spinBackToBack", 32'(outValidSeen), 32'd1);
    end
    drain();
    checkOutput("spinCount", 32'(gotQ.size()), 32'd4);
    if (gotQ.size() == 4) begin
      checkOutput("spin0", gotQ[0], 32'h2);
      checkOutput("spin1", gotQ[1], 32'h4);
      checkOutput("spin2", gotQ[2], 32'h8);
      checkOutput("spin3", gotQ[3], 32'h10);
    end
`else
    // Without the spin feature the spin request bit is ignored.
    gotQ.delete();
    applyStimulus(1'b1, 2'b00, 5'd1, 1'b1, 32'hA5A5A5A5, 1'b1);
    drain();
    checkOutput("noSpinCount", 32'(gotQ.size()), 32'd1);
    if (gotQ.size() == 1) checkOutput("noSpinValue", gotQ[0], 32'hD2D2D2D2);
`endif

    // Back-pressure: five stalled cycles while three requests are offered.
    gotQ.delete();
    reqData[0] = 32'h0000F00D;
    reqData[1] = 32'hCAFE0001;
    reqData[2] = 32'h13579BDF;
    firstRes   = modelOp(2'b01, 3, reqData[0]);
    accepts    = 0;
    head       = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 2'b01, 5'd3, 1'b0, reqData[head], 1'b0);
      if (lastAccepted) begin
        accepts++;
        head++;
      end
      if (c >= 2) checkOutput("stallInReadyLow", 32'(inReadySeen), 32'd0);
      if (c >= 3) checkOutput("stallDataStable", outDataSeen, firstRes);
    end
    checkOutput("stallAccepts", 32'(accepts), 32'd2);
    for (int c = 0; c < 10 && head < 3; c++) begin
      applyStimulus(1'b1, 2'b01, 5'd3, 1'b0, reqData[head], 1'b1);
      if (lastAccepted) head++;
    end
    idle(1);
    drain();
    checkOutput("stallResultCount", 32'(gotQ.size()), 32'd3);
    if (gotQ.size() == 3) checkOutput("stallThird", gotQ[2], modelOp(2'b01, 3, reqData[2]));

    // Reset with both stages full discards everything immediately.
    applyStimulus(1'b1, 2'b11, 5'd2, 1'b0, 32'h0000FFFF, 1'b0);
    applyStimulus(1'b1, 2'b11, 5'd2, 1'b0, 32'h00FF00FF, 1'b0);
    applyStimulus(1'b0, 2'b00, 5'd0, 1'b0, '0, 1'b0);
    checkOutput("fullBeforeReset", 32'({outValidSeen, inReadySeen}), 32'b10);
    @(negedge clock);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstOutData", out_data, 32'h0);
    expQ.delete();
    lastResult = '0;
    @(negedge clock);
    reset_n = 1'b1;
    gotQ.delete();
    applyStimulus(1'b1, 2'b00, 5'd3, 1'b1, 32'hF0F00000, 1'b1);
    drain();
    checkOutput("postRstCount", 32'(gotQ.size()), 32'd1);
`ifdef SPINNER_SPIN_EN
    if (gotQ.size() == 1) checkOutput("postRstSpinZero", gotQ[0], 32'h0);
`endif

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom),
                    1'($urandom), W'($urandom), 1'($urandom_range(0, 9) < 7));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/spinner_pipe.md
# spinner_pipe

Parametrised, pipelined barrel rotator/shifter: next generation of the 32-bit spinner. Accepts an operand, a shift amount and an operation code over a valid/ready handshake. Returns the rotated or shifted result two cycles later. Optionally recirculates its own previous result as the next operand ("spin"). Sits in the datapath between the operand-fetch stage and the result bus; it is the spinner used wherever a width other than 32 or back-pressure is needed.

## Interface
- WIDTH, 32, data width; power of two, 4..128.
- AMT_W, $clog2(WIDTH), derived width of the amount field; do not override.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- in_op  input  2  operation: 00 rotate right, 01 rotate left, 10 logical shift right, 11 logical shift left.
- in_amount  input  AMT_W  shift distance 0..WIDTH-1.
- in_spin  input  1  operand is the last produced result instead of in_data (only with SPINNER_SPIN_EN).
- in_data  input  WIDTH  operand.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result when out_valid && out_ready.
- out_data  output  WIDTH  result.

## Operation
- Stage 1 (S1) registers: s1_valid, op, amount, spin, data.
- Between S1 and stage 2 (S2), a combinational log-shifter applies AMT_W cascaded layers. Layer k moves by 2^k when amount[k] = 1.
  - Rotate: bits wrap around.
  - Logical shift: vacated bits are 0.
- S2 registers: out_valid, out_data.
- Amount 0 passes the operand unchanged for all ops.
- Amount is always < WIDTH; no modulo handling is needed.
- Spin operand: when the S1 entry has spin = 1, the shifter input is the current out_data register, not S1 data.
  - out_data holds the most recently produced result even after it is consumed.
  - The predecessor's result is therefore always the operand, including back-to-back spins.
  - The S1 data field is don't-care for spin entries.
- S1 advances into S2 when s1_valid && (!out_valid || out_ready).
- in_ready = !s1_valid || (S1 advances this cycle). This gives full throughput of one result per cycle with no bubbles.
- out_data only changes when S2 loads; it is stable while out_valid && !out_ready.
- Requests are never dropped or reordered.

## Timing
- Reset (async assert, sync release is the integrator's job):
  - s1_valid = 0, out_valid = 0.
  - out_data = 0, all S1 fields = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Latency: request accepted at edge N appears with out_valid = 1 after edge N+1 when unstalled.
- Stall: out_valid && !out_ready holds S2. S1 fills; in_ready drops the cycle after S1 becomes occupied.
- Simultaneous consume and accept: S2 loads from S1 and S1 loads the new request on the same edge.
- Spin with no prior result after reset uses out_data = 0.
- Reset mid-operation: all in-flight entries are discarded. The next spin operand is 0.

## Configuration
- SPINNER_SPIN_EN defined: in_spin honoured as above; S1 carries the spin bit and the shifter input mux exists.
- SPINNER_SPIN_EN undefined: in_spin is ignored (port kept, unconnected internally). The operand is always in_data; no spin bit or mux is built.

## Test plan
- Reset, then WIDTH=32, op=00, amount=4, data=0x12345678 -> out_data=0x81234567, out_valid high 2 cycles after acceptance.
- op=01 amount=8 data=0x80000001 -> 0x00000180; op=10 amount=31 data=0x80000000 -> 0x00000001; op=11 amount=1 data=0x80000001 -> 0x00000002.
- Back-to-back with SPINNER_SPIN_EN: request data=0x00000001 op=01 amount=1, then three spin requests op=01 amount=1 with in_data=0xFFFFFFFF -> results 0x2, 0x4, 0x8, 0x10 on consecutive cycles.
- Back-pressure: out_ready=0 for 5 cycles while 3 requests are offered -> exactly 2 accepted, in_ready low, out_data stable. Release -> results in order, no loss or duplication.
- Reset asserted with both stages full -> out_valid=0 and out_data=0 immediately. After release, spin op=00 amount=3 -> 0x00000000.
- Build without SPINNER_SPIN_EN: in_spin=1, in_data=0xA5A5A5A5, op=00 amount=1 -> 0xD2D2D2D2.
